echo_sequencer: RTL and testbench

Programmable spin-echo pulse sequencer that drives the RF switch line.
- On an accepted trigger it plays one echo shot: pi/2 pulse, tau gap, pi pulse, tau gap, pi/2 pulse.
- It repeats the shot a programmed number of times, with a holdoff gap between repetitions.
- It sits between the trigger input and the RF controller pin and replaces fixed free-running pulse generation with a latched, handshaked sequence.

---
 rtl/echo_sequencer.sv | 169 ++++++++++++++++
 tb/tb_echo_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/echo_sequencer.sv
// Spin-echo pulse sequencer: pi/2 - tau - pi - tau - pi/2, repeated n_rep times with holdoff.
// Optional macro SYNC_TRIG_EN adds a two-flop synchronizer on trig ahead of edge detection.
module echo_sequencer #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [CNT_W-1:0] pi2_len,
  input  logic [CNT_W-1:0] tau_len,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [REP_W-1:0] n_rep,
  output logic             rf,
  output logic             busy,
  output logic             done,
  output logic [2:0]       seg,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PI2_A = 3'd1,
    S_GAP1  = 3'd2,
    S_PI    = 3'd3,
    S_GAP2  = 3'd4,
    S_PI2_B = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  // One extra bit so the pi segment (2*pi2_len) never overflows.
  localparam int CW = CNT_W + 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] pi2_q, pi2_d, tau_q, tau_d, hold_q, hold_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             rf_q, rf_d, busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic             trig_in, trig_q, trig_d, rise, cnt_zero;

`ifdef SYNC_TRIG_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;
  always_comb begin
    sync1_d = trig;
    sync2_d = sync1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign trig_in = sync2_q;
`else
  assign trig_in = trig;
`endif

  assign trig_d   = trig_in;
  assign rise     = trig_in & ~trig_q;
  assign cnt_zero = (cnt_q == '0);

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pi2_q     <= '0;
      tau_q     <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      trig_q    <= 1'b0;
      rf_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pi2_q     <= pi2_d;
      tau_q     <= tau_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      trig_q    <= trig_d;
      rf_q      <= rf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and counter logic; counter holds L-1 on entry, segment ends at zero.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CW'(1);
    pi2_d     = pi2_q;
    tau_d     = tau_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    overrun_d = overrun_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rise) begin
          pi2_d     = pi2_len  | CNT_W'(pi2_len  == '0);
          tau_d     = tau_len  | CNT_W'(tau_len  == '0);
          hold_d    = hold_len | CNT_W'(hold_len == '0);
          rep_d     = n_rep    | REP_W'(n_rep    == '0);
          cnt_d     = {1'b0, pi2_d} - CW'(1);
          overrun_d = 1'b0;
          state_d   = S_PI2_A;
        end
      end
      S_PI2_A: if (cnt_zero) begin
        state_d = S_GAP1;
        cnt_d   = {1'b0, tau_q} - CW'(1);
      end
      S_GAP1: if (cnt_zero) begin
        state_d = S_PI;
        cnt_d   = {pi2_q, 1'b0} - CW'(1);
      end
      S_PI: if (cnt_zero) begin
        state_d = S_GAP2;
        cnt_d   = {1'b0, tau_q} - CW'(1);
      end
      S_GAP2: if (cnt_zero) begin
        state_d = S_PI2_B;
        cnt_d   = {1'b0, pi2_q} - CW'(1);
      end
      S_PI2_B: if (cnt_zero) begin
        rep_d = rep_q - REP_W'(1);
        if (rep_q > REP_W'(1)) begin
          state_d = S_HOLD;
          cnt_d   = {1'b0, hold_q} - CW'(1);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_HOLD: if (cnt_zero) begin
        state_d = S_PI2_A;
        cnt_d   = {1'b0, pi2_q} - CW'(1);
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (rise && busy_q) overrun_d = 1'b1;
  end

  // Registered outputs derived from the upcoming state.
  always_comb begin
    rf_d   = (state_d == S_PI2_A) || (state_d == S_PI) || (state_d == S_PI2_B);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_PI2_B) && cnt_zero && (rep_q <= REP_W'(1));
  end

  assign rf      = rf_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign seg     = state_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_echo_sequencer.sv
// Directed self-checking bench for echo_sequencer; expected rf patterns are built from the
// segment lengths of each shot and compared cycle by cycle.
module tb_echo_sequencer;
  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig;
  logic [CNT_W-1:0] pi2_len, tau_len, hold_len;
  logic [REP_W-1:0] n_rep;
  logic             rf, busy, done, overrun;
  logic [2:0]       seg;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  echo_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .trig(trig),
    .pi2_len(pi2_len), .tau_len(tau_len), .hold_len(hold_len), .n_rep(n_rep),
    .rf(rf), .busy(busy), .done(done), .seg(seg), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected rf waveform for n shots of p/t segments separated by h.
  task automatic build(input int p, input int t, input int h, input int n);
    exp_q.delete();
    for (int s = 0; s < n; s++) begin
      if (s > 0) for (int k = 0; k < h; k++) exp_q.push_back(1'b0);
      for (int k = 0; k < p; k++)     exp_q.push_back(1'b1);
      for (int k = 0; k < t; k++)     exp_q.push_back(1'b0);
      for (int k = 0; k < 2 * p; k++) exp_q.push_back(1'b1);
      for (int k = 0; k < t; k++)     exp_q.push_back(1'b0);
      for (int k = 0; k < p; k++)     exp_q.push_back(1'b1);
    end
  endtask

  // Play one triggered sequence; pe/te/he/ne are effective (clamped) lengths, blen the
  // hand-computed busy length, glitch the offset after which a second rise is injected.
  task automatic run_seq(input string name, input int p, input int t, input int h, input int n,
                         input int pe, input int te, input int he, input int ne,
                         input int blen, input int glitch);
    pi2_len  = CNT_W'(p);
    tau_len  = CNT_W'(t);
    hold_len = CNT_W'(h);
    n_rep    = REP_W'(n);
    build(pe, te, he, ne);
    trig = 1'b1;
`ifdef SYNC_TRIG_EN
    tick(); check({name, "_sync_wait0"}, busy, 0);
    tick(); check({name, "_sync_wait1"}, busy, 0);
`endif
    for (int i = 0; i <= blen; i++) begin
      tick();
      if (i == 0) begin
        trig     = 1'b0;
        // Config may change after accept without affecting the running sequence.
        pi2_len  = 16'd9;
        tau_len  = 16'd11;
        hold_len = 16'd13;
        n_rep    = 8'd5;
        check({name, "_seg_pi2a"}, seg, 1);
        check({name, "_ovr_clear"}, overrun, 0);
      end
      if (i == pe)      check({name, "_seg_gap1"}, seg, 2);
      if (i == pe + te) check({name, "_seg_pi"}, seg, 3);
      check({name, "_rf"},   rf,   (i < blen) ? exp_q[i] : 1'b0);
      check({name, "_busy"}, busy, (i < blen) ? 1 : 0);
      check({name, "_done"}, done, (i == blen) ? 1 : 0);
      if (i == blen) check({name, "_seg_idle"}, seg, 0);
      if (i == glitch)     trig = 1'b1;
      if (i == glitch + 1) trig = 1'b0;
    end
    if (glitch >= 0) check({name, "_overrun_set"}, overrun, 1);
    else             check({name, "_overrun_clr"}, overrun, 0);
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0;
    pi2_len = '0; tau_len = '0; hold_len = '0; n_rep = '0;
    #12;
    check("rst_rf", rf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seg", seg, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_busy", busy, 0);

    // Single shot: 3+5+6+5+3 = 22 busy cycles.
    run_seq("single", 3, 5, 7, 1, 3, 5, 7, 1, 22, -1);
    // Trigger on the cycle right after done is accepted: 3 shots of 12 plus 2 holds of 4.
    run_seq("repeat", 2, 2, 4, 3, 2, 2, 4, 3, 44, -1);
    tick();
    // Zero inputs clamp to 1: pattern 1,0,1,1,0,1.
    run_seq("clamp", 0, 0, 0, 0, 1, 1, 1, 1, 6, -1);
    tick();
    // Second rise mid-sequence: timing unaltered, overrun set.
    run_seq("ovr_mid", 3, 5, 7, 1, 3, 5, 7, 1, 22, 5);
    tick();
`ifndef SYNC_TRIG_EN
    // Rise sampled on the done edge is ignored.
    run_seq("ovr_done", 1, 1, 1, 1, 1, 1, 1, 1, 6, 5);
    tick();
    check("ovr_done_idle", busy, 0);
`endif
    // Two shots with a 1-cycle hold; accept clears overrun.
    run_seq("two_rep", 1, 3, 1, 2, 1, 3, 1, 2, 21, -1);
    tick();

    // Asynchronous reset mid-pi segment.
    pi2_len = 16'd3; tau_len = 16'd5; hold_len = 16'd1; n_rep = 8'd1;
    trig = 1'b1;
`ifdef SYNC_TRIG_EN
    repeat (2) tick();
`endif
    tick();
    trig = 1'b0;
    repeat (10) tick();
    check("mid_pi_rf", rf, 1);
    check("mid_pi_seg", seg, 3);
    #2 rst = 1'b1;
    #1;
    check("async_rf", rf, 0);
    check("async_busy", busy, 0);
    check("async_seg", seg, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_rf", rf, 0);
      check("post_rst_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
